// File: rtl/carregador_programa.sv
// rtl/carregador_programa.sv - program loader streaming bytes into the instruction memory write port
// Optional XOR checksum trailer: define CARREGADOR_CHECKSUM_EN.
module carregador_programa #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [ADDR_W:0] COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state;
    state_t            next_state;
    logic [DATA_W-1:0] len;
    logic              xfer;
    logic [ADDR_W:0]   count_inc;
    logic              last_byte;

`ifdef CARREGADOR_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
`endif

    assign xfer      = in_valid && in_ready;
    assign count_inc = count + COUNT_ONE;
    assign last_byte = (32'(count_inc) == 32'(len));

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (start) next_state = S_LEN;
            S_LEN: begin
                if (xfer) begin
                    if (32'(in_data) > MEM_DEPTH)
                        next_state = S_ERR;
                    else if (in_data == '0)
`ifdef CARREGADOR_CHECKSUM_EN
                        next_state = S_CSUM;
`else
                        next_state = S_DONE;
`endif
                    else
                        next_state = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer && last_byte)
`ifdef CARREGADOR_CHECKSUM_EN
                    next_state = S_CSUM;
`else
                    next_state = S_DONE;
`endif
            end
`ifdef CARREGADOR_CHECKSUM_EN
            S_CSUM: begin
                if (xfer)
                    next_state = ((checksum ^ in_data) == '0) ? S_DONE : S_ERR;
            end
`endif
            S_DONE:  next_state = S_IDLE;
            S_ERR:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // in_ready is derived from the upcoming state so it never depends on in_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            in_ready <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            cpu_hold <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            count    <= '0;
            len      <= '0;
`ifdef CARREGADOR_CHECKSUM_EN
            checksum <= '0;
`endif
        end else begin
            state    <= next_state;
            in_ready <= (next_state == S_LEN) || (next_state == S_DATA) ||
                        (next_state == S_CSUM);
            wr_en    <= (state == S_DATA) && xfer;

            if (state == S_IDLE && start) begin
                done     <= 1'b0;
                error    <= 1'b0;
                count    <= '0;
                cpu_hold <= 1'b1;
`ifdef CARREGADOR_CHECKSUM_EN
                checksum <= '0;
`endif
            end

            if (state == S_LEN && xfer)
                len <= in_data;

            if (state == S_DATA && xfer) begin
                wr_addr <= count[ADDR_W-1:0];
                wr_data <= in_data;
                count   <= count_inc;
`ifdef CARREGADOR_CHECKSUM_EN
                checksum <= checksum ^ in_data;
`endif
            end

            if (next_state == S_DONE) begin
                done     <= 1'b1;
                cpu_hold <= 1'b0;
            end
            if (next_state == S_ERR) begin
                error    <= 1'b1;
                cpu_hold <= 1'b0;
            end
        end
    end

endmodule

// File: doc/carregador_programa.md
Name: carregador_programa

Overview:
- Program loader: the write-side counterpart of the instruction ROM (`memoria_instrucoes`).
- Accepts a byte stream over a valid/ready handshake: length header, instruction bytes, then (optionally) a checksum byte.
- Writes each instruction byte sequentially into the instruction memory write port, starting at address 0.
- Holds the CPU stalled while loading and reports done/error, so a program (e.g. the 35-byte base algorithm or the 48-byte Fibonacci image) can be loaded at run time instead of via $readmemh.

Parameters:
- ADDR_W, 8, instruction memory address width (matches the 8-bit position bus).
- DATA_W, 8, instruction width.
- MEM_DEPTH, 256, number of writable words; header lengths above this are rejected.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a load session when idle.
- in_data  input  DATA_W  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts in_data this cycle.
- wr_en  output  1  instruction memory write strobe.
- wr_addr  output  ADDR_W  write address.
- wr_data  output  DATA_W  write data.
- cpu_hold  output  1  keeps the CPU in stall while a session is active.
- done  output  1  sticky; load completed successfully.
- error  output  1  sticky; load aborted (bad length or checksum).
- count  output  ADDR_W+1  words written in the current/last session.

Behaviour:
- Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=0, done=0, error=0, count=0, state IDLE, internal checksum=0.
- Transfer rule: a byte transfers only on a rising edge where in_valid=1 and in_ready=1. in_ready is a registered function of state only, never of in_valid.
- IDLE:
  - in_ready=0.
  - start=1 -> LEN; clear done, error, count and checksum; set cpu_hold=1.
- LEN:
  - in_ready=1.
  - On transfer, latch len=in_data.
  - len > MEM_DEPTH -> ERR.
  - len == 0 -> CSUM (or DONE without the feature).
  - Otherwise -> DATA.
- DATA:
  - in_ready=1.
  - Each transfer drives wr_en=1, wr_addr=count[ADDR_W-1:0], wr_data=in_data on the next cycle (1-cycle registered latency). wr_en is high exactly one cycle per accepted byte.
  - Each transfer increments count and updates checksum ^= in_data.
  - The transfer of byte number len -> CSUM.
  - No write is issued in a cycle without a transfer; in_valid gaps simply pause the session.
- CSUM:
  - in_ready=1.
  - On transfer, checksum ^ in_data == 0 -> DONE, else -> ERR.
- DONE:
  - done=1, cpu_hold=0, in_ready=0 -> IDLE next cycle. done stays high until the next start.
- ERR:
  - error=1, cpu_hold=0, in_ready=0 -> IDLE next cycle. error stays high until the next start.
  - Memory contents already written are left as-is.
- Boundary conditions:
  - start while not IDLE: ignored.
  - start and in_valid in the same IDLE cycle: the byte is not consumed, because in_ready=0 that cycle.
  - Address wrap cannot occur, because len ≤ MEM_DEPTH ≤ 2^ADDR_W.
  - Reset mid-session: all outputs return to reset values immediately (asynchronous). Partially written memory is not restored.

Optional Feature:
- Macro: CARREGADOR_CHECKSUM_EN.
- Defined: CSUM state present as described above; the session is XOR-checked.
- Undefined:
  - CSUM state and checksum register are removed.
  - After the last DATA transfer (or len==0 in LEN) the FSM goes straight to DONE.
  - error is raised only for len > MEM_DEPTH.

Test Plan:
- Feature on; start, stream 03,1A,2B,3C,0D (XOR=0x0D) with in_valid held high -> wr_en pulses at addr 0,1,2 with 1A,2B,3C; done=1, error=0, count=3, cpu_hold falls with done.
- Same stream with checksum byte 0x0E -> three writes occur, then error=1, done=0.
- MEM_DEPTH=35; header 0x30 (48) -> no writes, error=1 one cycle after the header transfer, in_ready=0 afterwards.
- Header 0x00 then checksum 0x00 -> zero writes, done=1, count=0.
- Load 35 bytes with in_valid toggling every other cycle and a start pulse mid-load -> exactly 35 writes at consecutive addresses 0..34, start ignored, done=1.
- rst_n low after 10 of 35 data bytes -> all outputs 0 asynchronously; a new start then loads from address 0 correctly.
